barrier_scheduler: RTL and testbench

- Central controller that owns up to NUM_BAR concurrent hardware barriers shared by NUM_PE processing elements.
- Software configures a barrier: its ID, the PE participant mask and an optional timeout. The block collects per-PE arrivals, then issues a one-cycle release pulse to every participant.
- Sits in the control subsystem between the command decoder (configuration side) and the PE array (arrive/release side).
- Prevents a PE from being enrolled in two live barriers at once, and reports misuse and timeouts.

---
 rtl/barrier_scheduler_pkg.sv | 18 +
 rtl/barrier_scheduler_slot.sv | 116 +++++++++++
 rtl/barrier_scheduler.sv | 126 ++++++++++++
 tb/tb_barrier_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrier_scheduler_pkg.sv
// barrier_scheduler_pkg
//   Shared definitions for the barrier scheduler: default sizing and the
//   per-slot FSM state encoding. Imported by barrier_slot and
//   barrier_scheduler.
package barrier_scheduler_pkg;

  localparam int DEF_NUM_PE  = 16;
  localparam int DEF_NUM_BAR = 4;
  localparam int DEF_BID_W   = 2;
  localparam int DEF_TO_W    = 16;

  typedef enum logic [1:0] {
    SLOT_IDLE    = 2'd0,
    SLOT_COLLECT = 2'd1,
    SLOT_RELEASE = 2'd2
  } slot_state_t;

endpackage

// File: rtl/barrier_scheduler_slot.sv
// barrier_slot
//   One hardware barrier slot: FSM (IDLE -> COLLECT -> RELEASE -> IDLE),
//   participant mask, arrived vector and timeout counter.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   arm             load arm_mask/arm_timeout and enter COLLECT (only acted on in IDLE)
//   arm_mask        participant mask for the new barrier
//   arm_timeout     cycles before abort; 0 = never
//   abort           drop the barrier without release (only acted on in COLLECT)
//   arrive          arrival strobes from PEs addressing this slot
//   legal           arrivals this slot accepts this cycle (combinational)
//   live_mask       participant mask while the slot is not IDLE
//   release_mask    registered release pulse to participants
//   done            registered completion pulse
//   busy            slot is not IDLE
//   timeout_hit     one-cycle pulse: the slot is timing out at this edge
module barrier_slot
  import barrier_scheduler_pkg::*;
#(
  parameter int NUM_PE = DEF_NUM_PE,
  parameter int TO_W   = DEF_TO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [NUM_PE-1:0] arm_mask,
  input  logic [TO_W-1:0]   arm_timeout,
  input  logic              abort,
  input  logic [NUM_PE-1:0] arrive,
  output logic [NUM_PE-1:0] legal,
  output logic [NUM_PE-1:0] live_mask,
  output logic [NUM_PE-1:0] release_mask,
  output logic              done,
  output logic              busy,
  output logic              timeout_hit
);

  slot_state_t       state;
  logic [NUM_PE-1:0] mask;
  logic [NUM_PE-1:0] arrived;
  logic [TO_W-1:0]   timeout;
  logic [TO_W-1:0]   count;
  logic [TO_W:0]     count_inc;
  logic              collecting;
  logic              complete;

  // Completion takes priority over timeout; abort is resolved in the FSM
  // after both, so a final arrival always beats a concurrent abort.
  always_comb begin
    collecting  = (state == SLOT_COLLECT);
    legal       = collecting ? (arrive & mask & ~arrived) : '0;
    complete    = collecting && ((arrived | legal) == mask);
    count_inc   = {1'b0, count} + {{TO_W{1'b0}}, 1'b1};
    timeout_hit = collecting && !complete && (timeout != '0) &&
                  (count_inc == {1'b0, timeout});
    busy        = (state != SLOT_IDLE);
    live_mask   = busy ? mask : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SLOT_IDLE;
      mask         <= '0;
      arrived      <= '0;
      timeout      <= '0;
      count        <= '0;
      release_mask <= '0;
      done         <= 1'b0;
    end else begin
      case (state)
        SLOT_IDLE: begin
          release_mask <= '0;
          done         <= 1'b0;
          if (arm) begin
            state   <= SLOT_COLLECT;
            mask    <= arm_mask;
            timeout <= arm_timeout;
            arrived <= '0;
            count   <= '0;
          end
        end
        SLOT_COLLECT: begin
          if (complete) begin
            state        <= SLOT_RELEASE;
            arrived      <= arrived | legal;
            release_mask <= mask;
            done         <= 1'b1;
          end else if (timeout_hit || abort) begin
            state   <= SLOT_IDLE;
            mask    <= '0;
            arrived <= '0;
            count   <= '0;
          end else begin
            arrived <= arrived | legal;
            if (timeout != '0) begin
              count <= count_inc[TO_W-1:0];
            end
          end
        end
        SLOT_RELEASE: begin
          state        <= SLOT_IDLE;
          mask         <= '0;
          arrived      <= '0;
          count        <= '0;
          release_mask <= '0;
          done         <= 1'b0;
        end
        default: begin
          state <= SLOT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/barrier_scheduler.sv
// barrier_scheduler
//   Owns NUM_BAR hardware barriers shared by NUM_PE processing elements.
//   Decodes configuration and abort requests, rejects configurations whose
//   mask overlaps a live barrier, routes per-PE arrivals to their slot and
//   keeps sticky error flags.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_*           configuration request (valid, id, mask, timeout)
//   cfg_ack/err     registered accept/reject pulse, one cycle after cfg_valid
//   abort_valid/id  abort request for a COLLECT slot
//   arrive_valid    per-PE arrival strobes
//   arrive_id       per-PE target slot, PE p at [p*BID_W +: BID_W]
//   pe_release      one-cycle release pulse per PE
//   bar_done        one-cycle completion pulse per slot
//   bar_busy        slot is not IDLE
//   timeout_err     sticky per-slot timeout flag
//   arrive_err      sticky per-PE illegal-arrival flag
//   err_clr         clears sticky flags (a same-cycle new error survives)
module barrier_scheduler
  import barrier_scheduler_pkg::*;
#(
  parameter int NUM_PE  = DEF_NUM_PE,
  parameter int NUM_BAR = DEF_NUM_BAR,
  parameter int BID_W   = DEF_BID_W,
  parameter int TO_W    = DEF_TO_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic [BID_W-1:0]        cfg_id,
  input  logic [NUM_PE-1:0]       cfg_mask,
  input  logic [TO_W-1:0]         cfg_timeout,
  output logic                    cfg_ack,
  output logic                    cfg_err,
  input  logic                    abort_valid,
  input  logic [BID_W-1:0]        abort_id,
  input  logic [NUM_PE-1:0]       arrive_valid,
  input  logic [NUM_PE*BID_W-1:0] arrive_id,
  output logic [NUM_PE-1:0]       pe_release,
  output logic [NUM_BAR-1:0]      bar_done,
  output logic [NUM_BAR-1:0]      bar_busy,
  output logic [NUM_BAR-1:0]      timeout_err,
  output logic [NUM_PE-1:0]       arrive_err,
  input  logic                    err_clr
);

  logic [NUM_BAR-1:0][NUM_PE-1:0] slot_arrive;
  logic [NUM_BAR-1:0][NUM_PE-1:0] slot_legal;
  logic [NUM_BAR-1:0][NUM_PE-1:0] slot_live;
  logic [NUM_BAR-1:0][NUM_PE-1:0] slot_release;
  logic [NUM_BAR-1:0]             slot_arm;
  logic [NUM_BAR-1:0]             slot_abort;
  logic [NUM_BAR-1:0]             slot_timeout;
  logic [NUM_PE-1:0]              live_or;
  logic [NUM_PE-1:0]              legal_or;
  logic [NUM_PE-1:0]              illegal;
  logic                           cfg_slot_idle;
  logic                           cfg_accept;

  // Decode requests against the pre-edge slot state. An id beyond NUM_BAR
  // never matches a slot, so it leaves cfg_slot_idle low and is rejected.
  always_comb begin
    live_or       = '0;
    legal_or      = '0;
    cfg_slot_idle = 1'b0;
    pe_release    = '0;
    for (int b = 0; b < NUM_BAR; b++) begin
      live_or    = live_or | slot_live[b];
      legal_or   = legal_or | slot_legal[b];
      pe_release = pe_release | slot_release[b];
      if (cfg_id == BID_W'(b)) begin
        cfg_slot_idle = !bar_busy[b];
      end
    end
    cfg_accept = cfg_slot_idle && ((cfg_mask & live_or) == '0);
    for (int b = 0; b < NUM_BAR; b++) begin
      slot_arm[b]   = cfg_valid && cfg_accept && (cfg_id == BID_W'(b));
      slot_abort[b] = abort_valid && (abort_id == BID_W'(b));
      for (int p = 0; p < NUM_PE; p++) begin
        slot_arrive[b][p] = arrive_valid[p] &&
                            (arrive_id[p*BID_W +: BID_W] == BID_W'(b));
      end
    end
    // Any strobe no slot claimed as legal is a misuse by that PE.
    illegal = arrive_valid & ~legal_or;
  end

  for (genvar b = 0; b < NUM_BAR; b++) begin : g_slot
    barrier_slot #(
      .NUM_PE (NUM_PE),
      .TO_W   (TO_W)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .arm          (slot_arm[b]),
      .arm_mask     (cfg_mask),
      .arm_timeout  (cfg_timeout),
      .abort        (slot_abort[b]),
      .arrive       (slot_arrive[b]),
      .legal        (slot_legal[b]),
      .live_mask    (slot_live[b]),
      .release_mask (slot_release[b]),
      .done         (bar_done[b]),
      .busy         (bar_busy[b]),
      .timeout_hit  (slot_timeout[b])
    );
  end

  // Sticky error flags: err_clr drops old bits but a new error this cycle
  // still lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ack     <= 1'b0;
      cfg_err     <= 1'b0;
      arrive_err  <= '0;
      timeout_err <= '0;
    end else begin
      cfg_ack     <= cfg_valid && cfg_accept;
      cfg_err     <= cfg_valid && !cfg_accept;
      arrive_err  <= (err_clr ? '0 : arrive_err) | illegal;
      timeout_err <= (err_clr ? '0 : timeout_err) | slot_timeout;
    end
  end

endmodule

// File: tb/tb_barrier_scheduler.sv
// tb_barrier_scheduler
//   Directed self-checking bench for barrier_scheduler. Inputs change and
//   outputs are sampled 1 time unit after each rising clock edge.
module tb_barrier_scheduler;

  localparam int NUM_PE  = 16;
  localparam int NUM_BAR = 4;
  localparam int BID_W   = 2;
  localparam int TO_W    = 16;

  logic                    clk;
  logic                    rst;
  logic                    cfg_valid;
  logic [BID_W-1:0]        cfg_id;
  logic [NUM_PE-1:0]       cfg_mask;
  logic [TO_W-1:0]         cfg_timeout;
  logic                    cfg_ack;
  logic                    cfg_err;
  logic                    abort_valid;
  logic [BID_W-1:0]        abort_id;
  logic [NUM_PE-1:0]       arrive_valid;
  logic [NUM_PE*BID_W-1:0] arrive_id;
  logic [NUM_PE-1:0]       pe_release;
  logic [NUM_BAR-1:0]      bar_done;
  logic [NUM_BAR-1:0]      bar_busy;
  logic [NUM_BAR-1:0]      timeout_err;
  logic [NUM_PE-1:0]       arrive_err;
  logic                    err_clr;

  int compareCount;
  int mismatchCount;

  barrier_scheduler #(
    .NUM_PE  (NUM_PE),
    .NUM_BAR (NUM_BAR),
    .BID_W   (BID_W),
    .TO_W    (TO_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_id       (cfg_id),
    .cfg_mask     (cfg_mask),
    .cfg_timeout  (cfg_timeout),
    .cfg_ack      (cfg_ack),
    .cfg_err      (cfg_err),
    .abort_valid  (abort_valid),
    .abort_id     (abort_id),
    .arrive_valid (arrive_valid),
    .arrive_id    (arrive_id),
    .pe_release   (pe_release),
    .bar_done     (bar_done),
    .bar_busy     (bar_busy),
    .timeout_err  (timeout_err),
    .arrive_err   (arrive_err),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Build an arrive_id vector routing every PE in mask to slot id.
  function automatic logic [NUM_PE*BID_W-1:0] idVec(input logic [NUM_PE-1:0] mask,
                                                    input int id);
    logic [NUM_PE*BID_W-1:0] v;
    v = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      if (mask[p]) v[p*BID_W +: BID_W] = BID_W'(id);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of requests, advance past the edge, then drop them.
  task automatic applyStimulus(input logic cv, input int cid,
                               input logic [NUM_PE-1:0] cmask, input int cto,
                               input logic [NUM_PE-1:0] avalid,
                               input logic [NUM_PE*BID_W-1:0] aid,
                               input logic abv, input int abid, input logic clr);
    cfg_valid    = cv;
    cfg_id       = BID_W'(cid);
    cfg_mask     = cmask;
    cfg_timeout  = TO_W'(cto);
    arrive_valid = avalid;
    arrive_id    = aid;
    abort_valid  = abv;
    abort_id     = BID_W'(abid);
    err_clr      = clr;
    tick();
    cfg_valid    = 1'b0;
    cfg_id       = '0;
    cfg_mask     = '0;
    cfg_timeout  = '0;
    arrive_valid = '0;
    arrive_id    = '0;
    abort_valid  = 1'b0;
    abort_id     = '0;
    err_clr      = 1'b0;
  endtask

  task automatic doCfg(input int id, input logic [NUM_PE-1:0] mask, input int to);
    applyStimulus(1'b1, id, mask, to, '0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic doArrive(input logic [NUM_PE-1:0] pes, input int id);
    applyStimulus(1'b0, 0, '0, 0, pes, idVec(pes, id), 1'b0, 0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, '0, 0, '0, '0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst          = 1'b1;
    cfg_valid    = 1'b0;
    cfg_id       = '0;
    cfg_mask     = '0;
    cfg_timeout  = '0;
    abort_valid  = 1'b0;
    abort_id     = '0;
    arrive_valid = '0;
    arrive_id    = '0;
    err_clr      = 1'b0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_busy", 32'(bar_busy), 32'h0);
    checkOutput("rst_release", 32'(pe_release), 32'h0);
    checkOutput("rst_done", 32'(bar_done), 32'h0);
    checkOutput("rst_ack", 32'(cfg_ack), 32'h0);
    checkOutput("rst_aerr", 32'(arrive_err), 32'h0);
    checkOutput("rst_terr", 32'(timeout_err), 32'h0);
    rst = 1'b0;
    tick();

    // Basic barrier: PEs 0..3 arrive spread out, gap before the last one
    $display("[TB] basic barrier");
    doCfg(0, 16'h000F, 0);
    checkOutput("basic_ack", 32'(cfg_ack), 32'h1);
    checkOutput("basic_noerr", 32'(cfg_err), 32'h0);
    checkOutput("basic_busy", 32'(bar_busy), 32'h1);
    doArrive(16'h0001, 0);
    doArrive(16'h0002, 0);
    doArrive(16'h0004, 0);
    checkOutput("basic_early_rel", 32'(pe_release), 32'h0);
    idle();
    checkOutput("basic_wait_busy", 32'(bar_busy), 32'h1);
    doArrive(16'h0008, 0);
    checkOutput("basic_release", 32'(pe_release), 32'h000F);
    checkOutput("basic_done", 32'(bar_done), 32'h1);
    idle();
    checkOutput("basic_rel_off", 32'(pe_release), 32'h0);
    checkOutput("basic_done_off", 32'(bar_done), 32'h0);
    checkOutput("basic_idle", 32'(bar_busy), 32'h0);

    // Overlap reject and retry
    $display("[TB] overlap");
    doCfg(0, 16'h00F0, 0);
    checkOutput("ovl_ack0", 32'(cfg_ack), 32'h1);
    doCfg(1, 16'h0180, 0);
    checkOutput("ovl_err", 32'(cfg_err), 32'h1);
    checkOutput("ovl_noack", 32'(cfg_ack), 32'h0);
    checkOutput("ovl_busy", 32'(bar_busy), 32'h1);
    doCfg(1, 16'h0300, 0);
    checkOutput("ovl_retry_ack", 32'(cfg_ack), 32'h1);
    checkOutput("ovl_busy2", 32'(bar_busy), 32'h3);
    doCfg(1, 16'h0400, 0);
    checkOutput("busy_slot_err", 32'(cfg_err), 32'h1);
    applyStimulus(1'b0, 0, '0, 0, '0, '0, 1'b1, 0, 1'b0);
    checkOutput("abort0_busy", 32'(bar_busy), 32'h2);
    applyStimulus(1'b0, 0, '0, 0, '0, '0, 1'b1, 1, 1'b0);
    checkOutput("abort1_busy", 32'(bar_busy), 32'h0);
    checkOutput("abort_no_rel", 32'(pe_release), 32'h0);

    // Illegal arrivals
    $display("[TB] illegal arrivals");
    doCfg(0, 16'h000F, 0);
    checkOutput("ill_ack", 32'(cfg_ack), 32'h1);
    doArrive(16'h0020, 0);
    checkOutput("ill_pe5", 32'(arrive_err), 32'h0020);
    doArrive(16'h0001, 0);
    checkOutput("ill_pe0_legal", 32'(arrive_err), 32'h0020);
    doArrive(16'h0001, 0);
    checkOutput("ill_pe0_dup", 32'(arrive_err), 32'h0021);
    checkOutput("ill_dup_norel", 32'(pe_release), 32'h0);
    doArrive(16'h000E, 0);
    checkOutput("ill_release", 32'(pe_release), 32'h000F);
    checkOutput("ill_done", 32'(bar_done), 32'h1);
    idle();
    applyStimulus(1'b0, 0, '0, 0, 16'h0080, idVec(16'h0080, 3), 1'b0, 0, 1'b1);
    checkOutput("clr_new_wins", 32'(arrive_err), 32'h0080);
    applyStimulus(1'b0, 0, '0, 0, '0, '0, 1'b0, 0, 1'b1);
    checkOutput("clr_aerr", 32'(arrive_err), 32'h0);

    // Timeout: armed edge ends cycle C; counter reaches 10 during C+10
    $display("[TB] timeout");
    doCfg(2, 16'h0003, 10);
    checkOutput("to_ack", 32'(cfg_ack), 32'h1);
    checkOutput("to_busy", 32'(bar_busy), 32'h4);
    doArrive(16'h0001, 2);
    for (int i = 0; i < 8; i++) begin
      checkOutput("to_no_rel", 32'(pe_release), 32'h0);
      idle();
    end
    checkOutput("to_still_busy", 32'(bar_busy), 32'h4);
    checkOutput("to_not_yet", 32'(timeout_err), 32'h0);
    idle();
    checkOutput("to_idle", 32'(bar_busy), 32'h0);
    checkOutput("to_err", 32'(timeout_err), 32'h4);
    checkOutput("to_no_release", 32'(pe_release), 32'h0);
    checkOutput("to_no_done", 32'(bar_done), 32'h0);
    applyStimulus(1'b0, 0, '0, 0, '0, '0, 1'b0, 0, 1'b1);
    checkOutput("to_clr", 32'(timeout_err), 32'h0);

    // Two slots complete together
    $display("[TB] concurrency");
    doCfg(0, 16'h000F, 0);
    checkOutput("cc_ack0", 32'(cfg_ack), 32'h1);
    doCfg(1, 16'hF000, 0);
    checkOutput("cc_ack1", 32'(cfg_ack), 32'h1);
    applyStimulus(1'b0, 0, '0, 0, 16'hF00F,
                  idVec(16'h000F, 0) | idVec(16'hF000, 1), 1'b0, 0, 1'b0);
    checkOutput("cc_release", 32'(pe_release), 32'hF00F);
    checkOutput("cc_done", 32'(bar_done), 32'h3);
    idle();
    checkOutput("cc_idle", 32'(bar_busy), 32'h0);

    // Empty mask completes with no releases
    $display("[TB] empty mask");
    doCfg(2, 16'h0000, 0);
    checkOutput("em_ack", 32'(cfg_ack), 32'h1);
    idle();
    checkOutput("em_done", 32'(bar_done), 32'h4);
    checkOutput("em_no_rel", 32'(pe_release), 32'h0);
    idle();
    checkOutput("em_idle", 32'(bar_busy), 32'h0);

    // Abort with the final arrival: completion wins
    $display("[TB] abort");
    doCfg(1, 16'h0006, 0);
    doArrive(16'h0002, 1);
    applyStimulus(1'b0, 0, '0, 0, 16'h0004, idVec(16'h0004, 1), 1'b1, 1, 1'b0);
    checkOutput("ab_fin_release", 32'(pe_release), 32'h0006);
    checkOutput("ab_fin_done", 32'(bar_done), 32'h2);
    idle();
    doCfg(1, 16'h0006, 0);
    applyStimulus(1'b0, 0, '0, 0, 16'h0002, idVec(16'h0002, 1), 1'b1, 1, 1'b0);
    checkOutput("ab_idle", 32'(bar_busy), 32'h0);
    checkOutput("ab_no_rel", 32'(pe_release), 32'h0);
    idle();
    checkOutput("ab_no_done", 32'(bar_done), 32'h0);

    // Reset mid-COLLECT discards the barrier
    $display("[TB] reset mid-barrier");
    doCfg(3, 16'h0030, 0);
    checkOutput("mr_ack", 32'(cfg_ack), 32'h1);
    doArrive(16'h0200, 3);
    checkOutput("mr_aerr", 32'(arrive_err), 32'h0200);
    rst = 1'b1;
    doArrive(16'h0030, 3);
    checkOutput("mr_busy", 32'(bar_busy), 32'h0);
    checkOutput("mr_release", 32'(pe_release), 32'h0);
    checkOutput("mr_aerr_clr", 32'(arrive_err), 32'h0);
    checkOutput("mr_ack_clr", 32'(cfg_ack), 32'h0);
    rst = 1'b0;
    idle();
    checkOutput("mr_no_rel", 32'(pe_release), 32'h0);
    checkOutput("mr_no_done", 32'(bar_done), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
